// File: rtl/input_collector_pkg.sv
// Shared types and constants for the input collector and its result streamer.
// Mode tags, result geometry and the stream drain FSM states.
package input_collector_pkg;

  localparam int MODE_WIDTH   = 4;
  localparam int RESULT_WIDTH = 128;
  localparam int BEAT_WIDTH   = 64;

  localparam logic [MODE_WIDTH-1:0] MODE_IDLE        = 4'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_COUNT       = 4'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_TIME_DETECT = 4'd2;
  localparam logic [MODE_WIDTH-1:0] MODE_MID_DETECT  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LO,
    ST_HI
  } stream_state_e;

endpackage

// File: rtl/sync_fifo_sdp.sv
// Synchronous FIFO on a simple dual-port RAM with a registered read port.
// Level is one bit wider than the pointers so a full FIFO is representable.
module sync_fifo_sdp #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 132,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;
  assign level_o   = level_q;
  assign rd_data_o = rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rd_ok) rd_data_q <= mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok) level_d = level_q + 1'b1;
    if (rd_ok && !wr_ok) level_d = level_q - 1'b1;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/input_result_streamer.sv
// Buffers 128-bit collector results with their mode tag and streams them
// to the host DMA as two 64-bit AXI4-Stream beats per word.
module input_result_streamer
  import input_collector_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int MODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_write,
  input  logic [RESULT_WIDTH-1:0] in_data,
  input  logic [MODE_WIDTH-1:0]   in_mode,
  input  logic                    clear,
  output logic [BEAT_WIDTH-1:0]   m_axis_tdata,
  output logic [MODE_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [31:0]             drop_count,
  output logic                    overflow
);

  localparam int FW = MODE_WIDTH + RESULT_WIDTH;

  stream_state_e   state_q, state_d;
  logic [FW-1:0]   out_q, out_d;
  logic [31:0]     drop_q, drop_d;
  logic            ovf_q, ovf_d;
  logic [FW-1:0]   rd_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic            wr_en;
  logic            rd_en;
  logic            drop;

  // Full is the registered flag, so a same-cycle pop never rescues a push.
  assign wr_en = in_write && !clear && !fifo_full;
  assign drop  = in_write && !clear && fifo_full;

  sync_fifo_sdp #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wr_en_i   (wr_en),
    .wr_data_i ({in_mode, in_data}),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clear) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    out_d         = out_q;
    rd_en         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !clear) begin
          rd_en   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        out_d   = rd_data;
        state_d = ST_LO;
      end
      ST_LO: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = out_q[BEAT_WIDTH-1:0];
        m_axis_tuser  = out_q[FW-1 -: MODE_WIDTH];
        if (m_axis_tready) state_d = ST_HI;
      end
      ST_HI: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = out_q[RESULT_WIDTH-1:BEAT_WIDTH];
        m_axis_tuser  = out_q[FW-1 -: MODE_WIDTH];
        if (m_axis_tready) begin
          if (!fifo_empty && !clear) begin
            rd_en   = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_input_result_streamer.sv
// Directed bench for input_result_streamer with a small FIFO (DEPTH=4).
// Beats are collected by a monitor and compared against hand-built words.
module tb_input_result_streamer;

  localparam int DEPTH = 4;
  localparam int MW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_write;
  logic [127:0]  in_data;
  logic [MW-1:0] in_mode;
  logic          clear;
  logic [63:0]   tdata;
  logic [MW-1:0] tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [LW-1:0] level;
  logic [31:0]   drop_count;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [68:0]  got_q [$];
  logic [68:0]  exp_q [$];
  logic         prev_stall = 1'b0;
  logic [68:0]  prev_beat  = '0;
  logic [127:0] wv [8];

  always #5 clk = ~clk;

  input_result_streamer #(
    .DEPTH      (DEPTH),
    .MODE_WIDTH (MW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_write      (in_write),
    .in_data       (in_data),
    .in_mode       (in_mode),
    .clear         (clear),
    .m_axis_tdata  (tdata),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .fifo_level    (level),
    .drop_count    (drop_count),
    .overflow      (overflow)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: records accepted beats, checks stall stability.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", tvalid, 1'b1);
        chk("stall_beat", {tuser, tlast, tdata}, prev_beat);
      end
      if (tvalid && tready) got_q.push_back({tuser, tlast, tdata});
      prev_stall = tvalid && !tready;
      prev_beat  = {tuser, tlast, tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [127:0] d, input logic [MW-1:0] m);
    in_write = 1'b1;
    in_data  = d;
    in_mode  = m;
    tick();
    in_write = 1'b0;
  endtask

  task automatic expect_word(input logic [127:0] d, input logic [MW-1:0] m);
    exp_q.push_back({m, 1'b0, d[63:0]});
    exp_q.push_back({m, 1'b1, d[127:64]});
  endtask

  task automatic drain_check(input string tag);
    int budget;
    budget = 300;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      tick();
      budget--;
    end
    repeat (8) tick();
    chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    wv[0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    wv[1] = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    wv[2] = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
    wv[3] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    wv[4] = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    wv[5] = 128'h1000_2000_3000_4000_5000_6000_7000_8000;
    wv[6] = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
    wv[7] = 128'hFFFF_0000_FFFF_0000_0000_FFFF_0000_FFFF;

    reset    = 1'b1;
    in_write = 1'b0;
    in_data  = '0;
    in_mode  = '0;
    clear    = 1'b0;
    tready   = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 64'h0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_count, 32'h0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick();

    // 1: single word, latency and beat split
    tready = 1'b1;
    expect_word(wv[0], 4'd2);
    push_word(wv[0], 4'd2);
    chk("t1_level", level, 1);
    chk("t1_valid_c0", tvalid, 1'b0);
    tick();
    chk("t1_valid_c1", tvalid, 1'b0);
    tick();
    chk("t1_valid_c2", tvalid, 1'b1);
    chk("t1_lo", tdata, 64'h8899_AABB_CCDD_EEFF);
    chk("t1_user", tuser, 4'd2);
    chk("t1_last", tlast, 1'b0);
    drain_check("t1");

    // 2: random backpressure over three words
    fork
      begin
        for (int i = 1; i < 4; i++) begin
          expect_word(wv[i], MW'(i + 4));
          push_word(wv[i], MW'(i + 4));
        end
      end
      begin
        repeat (30) begin
          tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    tready = 1'b1;
    drain_check("t2");
    chk("t2_drop", drop_count, 32'h0);

    // 3: overflow with tready held low
    tready = 1'b0;
    for (int i = 0; i < 5; i++) expect_word(wv[i], MW'(i));
    for (int i = 0; i < 7; i++) begin
      in_write = 1'b1;
      in_data  = wv[i];
      in_mode  = MW'(i);
      tick();
    end
    in_write = 1'b0;
    tick();
    chk("t3_level", level, 4);
    chk("t3_drop", drop_count, 32'd2);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_head", tdata, wv[0][63:0]);
    tready = 1'b1;
    drain_check("t3");
    chk("t3_level_end", level, 0);
    chk("t3_drop_sticky", drop_count, 32'd2);

    // 4: push on full with a same-cycle pop
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_clr_drop", drop_count, 32'h0);
    chk("t4_clr_ovf", overflow, 1'b0);
    tready = 1'b0;
    for (int i = 0; i < 5; i++) expect_word(wv[i], 4'd3);
    for (int i = 0; i < 5; i++) begin
      in_write = 1'b1;
      in_data  = wv[i];
      in_mode  = 4'd3;
      tick();
    end
    in_write = 1'b0;
    chk("t4_full", level, 4);
    tready = 1'b1;
    tick();
    chk("t4_in_hi", tlast, 1'b1);
    in_write = 1'b1;
    in_data  = wv[7];
    tick();
    in_write = 1'b0;
    tready   = 1'b0;
    chk("t4_level", level, 3);
    chk("t4_drop", drop_count, 32'd1);
    chk("t4_ovf", overflow, 1'b1);
    tready = 1'b1;
    drain_check("t4");

    // 5: clear while the upper beat is stalled
    tready = 1'b0;
    expect_word(wv[5], 4'd5);
    push_word(wv[5], 4'd5);
    push_word(wv[6], 4'd6);
    tick();
    chk("t5_lo_valid", tvalid, 1'b1);
    tready = 1'b1;
    tick();
    tready   = 1'b0;
    clear    = 1'b1;
    in_write = 1'b1;
    in_data  = wv[0];
    tick();
    clear    = 1'b0;
    in_write = 1'b0;
    chk("t5_level", level, 0);
    chk("t5_drop", drop_count, 32'h0);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_hi_valid", tvalid, 1'b1);
    chk("t5_hi_data", tdata, wv[5][127:64]);
    tick();
    chk("t5_level2", level, 0);
    tready = 1'b1;
    tick();
    tick();
    chk("t5_idle", tvalid, 1'b0);
    drain_check("t5");

    // 6: reset in the middle of a word
    tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_write = 1'b1;
      in_data  = wv[i];
      in_mode  = 4'd1;
      tick();
    end
    in_write = 1'b0;
    chk("t6_pre_valid", tvalid, 1'b1);
    chk("t6_pre_drop", drop_count, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", tvalid, 1'b0);
    chk("t6_level", level, 0);
    chk("t6_drop", drop_count, 32'h0);
    chk("t6_ovf", overflow, 1'b0);
    got_q.delete();
    tready = 1'b1;
    expect_word(wv[3], 4'd9);
    push_word(wv[3], 4'd9);
    drain_check("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
